// File: rtl/button_press_classifier.sv
`timescale 1ns/1ps
// button_press_classifier
//
// Classifies gestures on a clean, already-synchronous button level into
// short press, double press or long press, and emits auto-repeat pulses
// while a long press is held. All event outputs are registered
// single-cycle pulses, and at most one of them is high in any cycle.
//
// Ports:
//   i_clk     system clock
//   i_rst_n   asynchronous active-low reset
//   i_level   debounced button level, 1 = pressed
//   o_short   pulse: single short press, confirmed once the gap expires
//   o_double  pulse: second press started inside the gap window
//   o_long    pulse: press held for LONG_PRESS_CYCLES samples
//   o_repeat  pulse: every REPEAT_CYCLES after o_long while still held
//   o_busy    high while a gesture is in progress (not IDLE / ARM)
//
// state        | meaning
// -------------+--------------------------------------------------------
// ARM          | first cycle after reset; a level held through reset is
//              | routed to WAIT_RELEASE so it never produces an event
// IDLE         | waiting for a rising edge
// PRESS1       | first press in progress, counting toward a long press
// GAP          | released after a short first press, waiting for a
//              | second press or for the gap window to expire
// LONG_HELD    | long press reported, emitting repeats while held
// WAIT_RELEASE | ignore everything until the button is released

module button_press_classifier #(
    parameter int LONG_PRESS_CYCLES = 50_000_000,
    parameter int DOUBLE_GAP_CYCLES = 25_000_000,
    parameter int REPEAT_CYCLES     = 10_000_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_level,
    output logic o_short,
    output logic o_double,
    output logic o_long,
    output logic o_repeat,
    output logic o_busy
);

    localparam int MAX_LG  = (LONG_PRESS_CYCLES > DOUBLE_GAP_CYCLES) ?
                             LONG_PRESS_CYCLES : DOUBLE_GAP_CYCLES;
    localparam int MAX_ALL = (MAX_LG > REPEAT_CYCLES) ? MAX_LG : REPEAT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_ALL) + 1;

    // Terminal counts: the counter holds the number of qualifying samples
    // already seen, so an event fires when it equals (cycles - 1).
    localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'(DOUBLE_GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_TC  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_ARM          = 3'd0,
        ST_IDLE         = 3'd1,
        ST_PRESS1       = 3'd2,
        ST_GAP          = 3'd3,
        ST_LONG_HELD    = 3'd4,
        ST_WAIT_RELEASE = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              level_q, level_d;
    logic              short_q, short_d;
    logic              double_q, double_d;
    logic              long_q, long_d;
    logic              repeat_q, repeat_d;
    logic              busy_q, busy_d;

    logic rise;
    logic fall;

    assign rise = i_level & ~level_q;
    assign fall = ~i_level & level_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        level_d  = i_level;
        short_d  = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
        repeat_d = 1'b0;

        case (state_q)
            ST_ARM: begin
                state_d = i_level ? ST_WAIT_RELEASE : ST_IDLE;
            end
            ST_IDLE: begin
                if (rise) begin
                    cnt_d   = CNT_ONE;
                    state_d = ST_PRESS1;
                end
            end
            ST_PRESS1: begin
                // Completing the long count wins over a release on the same edge.
                if (cnt_q == LONG_TC) begin
                    long_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_LONG_HELD;
                end else if (i_level) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else if (fall) begin
                    cnt_d   = CNT_ONE;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (rise) begin
                    double_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_WAIT_RELEASE;
                end else if (cnt_q == GAP_TC) begin
                    short_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_LONG_HELD: begin
                if (!i_level) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q == REP_TC) begin
                    // Wrap after each repeat so hold length is unbounded.
                    repeat_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_WAIT_RELEASE: begin
                if (!i_level) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE) && (state_d != ST_ARM);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_ARM;
            cnt_q    <= '0;
            level_q  <= 1'b0;
            short_q  <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            short_q  <= short_d;
            double_q <= double_d;
            long_q   <= long_d;
            repeat_q <= repeat_d;
            busy_q   <= busy_d;
        end
    end

    assign o_short  = short_q;
    assign o_double = double_q;
    assign o_long   = long_q;
    assign o_repeat = repeat_q;
    assign o_busy   = busy_q;

endmodule

// File: tb/tb_button_press_classifier.sv
`timescale 1ns/1ps
// Testbench for button_press_classifier with LONG=20, GAP=10, REPEAT=5.
// Expected pulses (kind + edge index) are queued as stimulus is planned;
// a negedge monitor pops and compares every pulse the DUT produces.

module tb_button_press_classifier;

    localparam int LONG_C = 20;
    localparam int GAP_C  = 10;
    localparam int REP_C  = 5;

    localparam int K_SHORT  = 0;
    localparam int K_DOUBLE = 1;
    localparam int K_LONG   = 2;
    localparam int K_REPEAT = 3;

    typedef struct {
        int kind;
        int edge_n;
    } exp_t;

    logic i_clk;
    logic i_rst_n;
    logic i_level;
    logic o_short;
    logic o_double;
    logic o_long;
    logic o_repeat;
    logic o_busy;

    int   cyc;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    button_press_classifier #(
        .LONG_PRESS_CYCLES(LONG_C),
        .DOUBLE_GAP_CYCLES(GAP_C),
        .REPEAT_CYCLES    (REP_C)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_level (i_level),
        .o_short (o_short),
        .o_double(o_double),
        .o_long  (o_long),
        .o_repeat(o_repeat),
        .o_busy  (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    function automatic string kind_name(input int k);
        case (k)
            K_SHORT:  return "short";
            K_DOUBLE: return "double";
            K_LONG:   return "long";
            default:  return "repeat";
        endcase
    endfunction

    task automatic push_exp(input int kind, input int edge_n);
        exp_t e;
        e.kind   = kind;
        e.edge_n = edge_n;
        exp_q.push_back(e);
    endtask

    // Called at a negedge: level v is sampled on the next n rising edges.
    task automatic hold(input logic v, input int n);
        i_level = v;
        repeat (n) @(negedge i_clk);
    endtask

    // Scoreboard monitor: every pulse must match the head of the queue.
    always @(negedge i_clk) begin
        logic [3:0] pulses;
        exp_t       e;
        pulses = {o_repeat, o_long, o_double, o_short};
        if (pulses != 4'b0) begin
            checks++;
            if ($countones(pulses) > 1) begin
                errors++;
                $display("FAIL one_hot: edge %0d pulses=%b, required at most one", cyc, pulses);
            end
            for (int k = 0; k < 4; k++) begin
                if (pulses[k]) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_pulse: %s at edge %0d, required none",
                                 kind_name(k), cyc);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.kind !== k || e.edge_n !== cyc) begin
                            errors++;
                            $display("FAIL pulse: got %s at edge %0d, required %s at edge %0d",
                                     kind_name(k), cyc, kind_name(e.kind), e.edge_n);
                        end
                    end
                end
            end
        end
    end

    task automatic drain_check(input string name);
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL %s_drain: %0d expected pulses missing, next %s at edge %0d",
                     name, exp_q.size(), kind_name(exp_q[0].kind), exp_q[0].edge_n);
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_level = 1'b0;
        repeat (3) @(negedge i_clk);
        checks++;
        if ({o_short, o_double, o_long, o_repeat, o_busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, required 00000",
                     {o_short, o_double, o_long, o_repeat, o_busy});
        end
        i_rst_n = 1'b1;
        hold(1'b0, 1);
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy: got %b, required 0", o_busy);
        end
        hold(1'b0, 3);
        drain_check("reset");
    endtask

    task automatic test_short();
        int r;
        r = cyc + 1;
        push_exp(K_SHORT, r + 14);
        hold(1'b1, 1);
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL short_busy_start: got %b, required 1", o_busy);
        end
        hold(1'b1, 4);
        hold(1'b0, 9);
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL short_busy_gap: got %b, required 1", o_busy);
        end
        hold(1'b0, 1);
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL short_busy_end: got %b, required 0", o_busy);
        end
        hold(1'b0, 6);
        drain_check("short");
    endtask

    task automatic test_double();
        int r;
        r = cyc + 1;
        push_exp(K_DOUBLE, r + 9);
        hold(1'b1, 5);
        hold(1'b0, 4);
        hold(1'b1, 30);
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL double_busy_held: got %b, required 1", o_busy);
        end
        hold(1'b0, 1);
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL double_busy_release: got %b, required 0", o_busy);
        end
        hold(1'b0, 14);
        drain_check("double");
    endtask

    task automatic test_long_repeat();
        int r;
        r = cyc + 1;
        push_exp(K_LONG,   r + LONG_C - 1);
        push_exp(K_REPEAT, r + LONG_C - 1 + REP_C);
        push_exp(K_REPEAT, r + LONG_C - 1 + 2 * REP_C);
        hold(1'b1, 32);
        hold(1'b0, 1);
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL long_busy_release: got %b, required 0", o_busy);
        end
        hold(1'b0, 15);
        drain_check("long");
    endtask

    task automatic test_gap_boundary();
        int r;
        r = cyc + 1;
        push_exp(K_DOUBLE, r + 14);
        hold(1'b1, 5);
        hold(1'b0, 9);
        hold(1'b1, 3);
        hold(1'b0, 3);
        drain_check("gap_edge_double");
        r = cyc + 1;
        push_exp(K_SHORT, r + 14);
        hold(1'b1, 5);
        hold(1'b0, 10);
        r = cyc + 1;
        push_exp(K_SHORT, r + 14);
        hold(1'b1, 5);
        hold(1'b0, 14);
        drain_check("gap_edge_short");
    endtask

    task automatic test_held_through_reset();
        int r;
        i_rst_n = 1'b0;
        i_level = 1'b1;
        repeat (3) @(negedge i_clk);
        checks++;
        if ({o_short, o_double, o_long, o_repeat, o_busy} !== 5'b0) begin
            errors++;
            $display("FAIL held_reset_outputs: got %b, required 00000",
                     {o_short, o_double, o_long, o_repeat, o_busy});
        end
        i_rst_n = 1'b1;
        hold(1'b1, 40);
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL held_busy_wait: got %b, required 1", o_busy);
        end
        hold(1'b0, 5);
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL held_busy_release: got %b, required 0", o_busy);
        end
        r = cyc + 1;
        push_exp(K_SHORT, r + 14);
        hold(1'b1, 5);
        hold(1'b0, 14);
        drain_check("held_reset");
    endtask

    task automatic test_reset_mid_gap();
        int r;
        hold(1'b1, 5);
        hold(1'b0, 3);
        i_rst_n = 1'b0;
        hold(1'b0, 1);
        checks++;
        if ({o_short, o_double, o_long, o_repeat, o_busy} !== 5'b0) begin
            errors++;
            $display("FAIL midgap_reset_outputs: got %b, required 00000",
                     {o_short, o_double, o_long, o_repeat, o_busy});
        end
        hold(1'b0, 2);
        i_rst_n = 1'b1;
        hold(1'b0, 20);
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL midgap_busy: got %b, required 0", o_busy);
        end
        r = cyc + 1;
        push_exp(K_SHORT, r + 14);
        hold(1'b1, 5);
        hold(1'b0, 14);
        drain_check("midgap");
    endtask

    // Reset asserted while o_long is high must drop it without a clock edge.
    task automatic test_async_reset();
        hold(1'b1, LONG_C - 1);
        @(posedge i_clk);
        #1;
        checks++;
        if (o_long !== 1'b1) begin
            errors++;
            $display("FAIL async_long_high: got %b, required 1", o_long);
        end
        i_rst_n = 1'b0;
        i_level = 1'b0;
        #1;
        checks++;
        if (o_long !== 1'b0) begin
            errors++;
            $display("FAIL async_long_drop: got %b, required 0", o_long);
        end
        @(negedge i_clk);
        hold(1'b0, 2);
        i_rst_n = 1'b1;
        hold(1'b0, 10);
        drain_check("async");
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        i_rst_n = 1'b0;
        i_level = 1'b0;
        @(negedge i_clk);
        test_reset();
        test_short();
        test_double();
        test_long_repeat();
        test_gap_boundary();
        test_held_through_reset();
        test_reset_mid_gap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
